// File: rtl/data_mem_lsu.sv
// Word-organised data memory with an RV32I load/store front end.
// One request in flight: IDLE -> [WAIT x WAIT_CYCLES] -> RESP -> IDLE.
module data_mem_lsu #(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [2:0]  WLAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept, enter_resp;
    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        oor, illegal, misal, acc_err;
    logic [3:0]  st_mask;
    logic [31:0] st_data, rd_word, rd_shift, ld_val;

    logic [31:0] mem [DEPTH];

    assign accept    = req_valid & req_ready_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With no wait states the access edge is the accept edge, so the live
    // inputs are exactly what gets latched there; otherwise use the latch.
    always_comb begin
        if (state_q == IDLE) begin
            a_we    = req_we;
            a_f3    = req_funct3;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end else begin
            a_we    = we_q;
            a_f3    = funct3_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (WAIT_CYCLES == 0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = 3'd0;
                end
            end
            WAIT: if (wait_cnt_q == WLAST) begin
                state_d    = RESP;
                enter_resp = 1'b1;
                wait_cnt_d = 3'd0;
            end else begin
                wait_cnt_d = wait_cnt_q + 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        offset  = a_addr - BASE_ADDR;
        idx     = offset[AW+1:2];
        oor     = {1'b0, offset} >= LIMIT;
        illegal = a_we ? (a_f3 > 3'd2)
                       : (a_f3 == 3'd3 || a_f3 == 3'd6 || a_f3 == 3'd7);
        misal   = (a_f3[1:0] == 2'd1 && a_addr[0]) ||
                  (a_f3[1:0] == 2'd2 && a_addr[1:0] != 2'd0);
        acc_err = oor | illegal | misal;

        case (a_f3)
            3'd0:    begin st_mask = 4'b0001 << a_addr[1:0]; st_data = {4{a_wdata[7:0]}};  end
            3'd1:    begin st_mask = 4'b0011 << a_addr[1:0]; st_data = {2{a_wdata[15:0]}}; end
            default: begin st_mask = 4'b1111;                st_data = a_wdata;            end
        endcase

        rd_word  = mem[idx];
        rd_shift = rd_word >> {a_addr[1:0], 3'b000};
        case (a_f3)
            3'd0:    ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    ld_val = {24'b0, rd_shift[7:0]};
            3'd5:    ld_val = {16'b0, rd_shift[15:0]};
            default: ld_val = rd_word;
        endcase

        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || a_we) ? 32'd0 : ld_val;
        end
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 3'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array is never reset; byte-masked write on the RESP-entry edge only.
    always_ff @(posedge clk) begin
        if (enter_resp && a_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench: u0 has no wait states, u3 has three; responses are
// checked by a monitor against expectations queued at each accept.
module tb_data_mem_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        vld   [2];
    logic        we    [2];
    logic [2:0]  f3    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic [31:0] rd    [2];
    logic        er    [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q3[$];

    data_mem_lsu #(.DEPTH(4096), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(we[0]), .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

    data_mem_lsu #(.DEPTH(4096), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(we[1]), .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wd[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, " req_ready"}, {31'b0, rdy[d]}, 32'd1);
        chk({tag, " rsp_valid"}, {31'b0, rv[d]}, 32'd0);
        chk({tag, " rsp_rdata"}, rd[d], 32'd0);
        chk({tag, " rsp_err"},   {31'b0, er[d]}, 32'd0);
    endtask

    // Monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rv[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q3.size() == 0)) begin
                    ntests++;
                    nfail++;
                    $display("FAIL u%0d unexpected_rsp: got rsp_valid=1 expected none", d * 3);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q3.pop_front();
                    chk($sformatf("u%0d rsp_rdata", d * 3), rd[d], e.rd);
                    chk($sformatf("u%0d rsp_err", d * 3), {31'b0, er[d]}, {31'b0, e.err});
                    chk($sformatf("u%0d rsp_cycle", d * 3), cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] data,
                         input logic [31:0] erd, input logic eerr, input bit now = 0);
        exp_t e;
        int   n;
        if (!now) @(negedge clk);
        vld[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wd[d] = data;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rdy[d] !== 1'b1) begin
            ntests++;
            nfail++;
            $display("FAIL u%0d issue_timeout: got req_ready=%b expected 1", d * 3, rdy[d]);
            vld[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.rd  = erd;
        e.err = eerr;
        e.cyc = cyc + (d == 0 ? 0 : 3);
        if (d == 0) q0.push_back(e);
        else        q3.push_back(e);
        // Scramble inputs so any use of live inputs after accept shows up.
        vld[d] = 1'b0; we[d] = ~w; f3[d] = 3'd7; addr[d] = 32'hFFFF_FFFF; wd[d] = 32'h5A5A_5A5A;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1; vld[d] = 1'b0; we[d] = 1'b0;
            f3[d] = 3'd0; addr[d] = 32'd0; wd[d] = 32'd0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        #3;
        chk_reset(0, "u0 reset");
        chk_reset(1, "u3 reset");
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Basic word store/load, then output hold between responses.
        issue(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        repeat (4) @(negedge clk);
        chk("u0 rdata_hold", rd[0], 32'hDEAD_BEEF);

        // Sign/zero extension by lane.
        issue(0, 1, 3'd2, 32'h10, 32'h80FF_7F01, 32'h0, 0);
        issue(0, 0, 3'd0, 32'h13, 32'h0, 32'hFFFF_FF80, 0);
        issue(0, 0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 0);
        issue(0, 0, 3'd1, 32'h12, 32'h0, 32'hFFFF_80FF, 0);
        issue(0, 0, 3'd5, 32'h12, 32'h0, 32'h0000_80FF, 0);

        // Byte and halfword merge.
        issue(0, 1, 3'd2, 32'h20, 32'h0, 32'h0, 0);
        issue(0, 1, 3'd0, 32'h21, 32'h0000_00AB, 32'h0, 0);
        issue(0, 1, 3'd1, 32'h22, 32'h0000_1234, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h20, 32'h0, 32'h1234_AB00, 0);
        issue(0, 0, 3'd0, 32'h21, 32'h0, 32'hFFFF_FFAB, 0);
        issue(0, 0, 3'd0, 32'h20, 32'h0, 32'h0000_0000, 0);

        // Faults: misaligned, out of range, illegal; none may write.
        issue(0, 1, 3'd2, 32'h0, 32'h1111_1111, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h11, 32'h0, 32'h0, 1);
        issue(0, 0, 3'd1, 32'h13, 32'h0, 32'h0, 1);
        issue(0, 1, 3'd2, 32'h4000, 32'h0000_0055, 32'h0, 1);
        issue(0, 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
        issue(0, 1, 3'd2, 32'h22, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 1, 3'd1, 32'h13, 32'h0000_FFFF, 32'h0, 1);
        issue(0, 1, 3'd4, 32'h20, 32'h0000_00EE, 32'h0, 1);
        issue(0, 0, 3'd2, 32'h10, 32'h0, 32'h80FF_7F01, 0);
        issue(0, 0, 3'd2, 32'h0, 32'h0, 32'h1111_1111, 0);
        issue(0, 0, 3'd2, 32'h20, 32'h0, 32'h1234_AB00, 0);

        // Last word in range versus first word past the end.
        issue(0, 1, 3'd2, 32'h3FFC, 32'h0000_007E, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h3FFC, 32'h0, 32'h0000_007E, 0);
        issue(0, 0, 3'd2, 32'h4000, 32'h0, 32'h0, 1);

        // Wait-state block: continuous req_valid and ready pattern.
        issue(1, 1, 3'd2, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        @(negedge clk);
        n = 0;
        while (rdy[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vld[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'd2; addr[1] = 32'h10; wd[1] = 32'h0;
        chk("u3 ready_pat0", {31'b0, rdy[1]}, 32'd1);
        @(posedge clk);
        #1;
        q3.push_back('{rd: 32'hCAFE_F00D, err: 1'b0, cyc: cyc + 3});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("u3 ready_pat%0d", k), {31'b0, rdy[1]}, (k == 5) ? 32'd1 : 32'd0);
        end
        vld[1] = 1'b0;

        // Reset in the second WAIT cycle aborts the store.
        issue(1, 1, 3'd2, 32'h30, 32'h0102_0304, 32'h0, 0);
        issue(1, 0, 3'd2, 32'h30, 32'h0, 32'h0102_0304, 0);
        @(negedge clk);
        n = 0;
        while (rdy[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vld[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'd2; addr[1] = 32'h30; wd[1] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk_reset(1, "u3 abort");
        @(negedge clk);
        rst_n[1] = 1'b1;
        issue(1, 0, 3'd2, 32'h30, 32'h0, 32'h0102_0304, 0, 1);

        repeat (10) @(negedge clk);
        chk("u0 queue_drained", q0.size(), 32'd0);
        chk("u3 queue_drained", q3.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit words; it is a power of two, minimum 16.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the extra access wait states, range 0..7.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0; it is aligned to DEPTH*4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_funct3, input, 3 bits: RV32I width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-010 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, LSB-justified.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle response strobe.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load result, extended to 32 bits.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the request faulted; qualified by rsp_valid.

Function
REQ-015 The block SHALL implement the FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 The block SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching we, funct3, addr and wdata at that edge.
REQ-017 On accept, the FSM SHALL go IDLE->RESP if WAIT_CYCLES=0, else IDLE->WAIT, staying in WAIT for exactly WAIT_CYCLES cycles, then WAIT->RESP.
REQ-018 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP; RESP->IDLE is unconditional, with no response backpressure.
REQ-019 Latency SHALL be rsp_valid high WAIT_CYCLES+1 cycles after the accept edge; peak throughput is one request per WAIT_CYCLES+2 cycles.
REQ-020 Array access (read or write) SHALL occur on the edge entering RESP, using the latched request only; input changes after accept SHALL have no effect.
REQ-021 The word index SHALL be (addr-BASE_ADDR)>>2; an access is out of range when (addr-BASE_ADDR) >= DEPTH*4 (unsigned).
REQ-022 A halfword access SHALL be misaligned when addr[0]=1, and a word access when addr[1:0]!=0; byte accesses never misalign.
REQ-023 The block SHALL treat as illegal any load funct3 of 3, 6 or 7 and any store funct3 not in {0,1,2}.
REQ-024 An out-of-range, misaligned or illegal request SHALL drive rsp_err=1 and rsp_rdata=0, with no array write.
REQ-025 A store SHALL use a byte mask of B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111, with data replicated into lanes (B x4, H x2); only masked bytes are written.
REQ-026 A load SHALL select the lane by addr[1:0]; B/H SHALL sign-extend from bit 7/15, BU/HU SHALL zero-extend, and W passes through.
REQ-027 A successful store SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-028 rsp_rdata and rsp_err SHALL hold their last values outside RESP until the next response.
REQ-029 Array contents SHALL NOT be reset; the array SHALL infer block RAM, with a read-modify-write merge permitted.

Reset
REQ-030 While rst_n=0 the block SHALL force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter to 0, asynchronously.
REQ-031 Reset asserted in WAIT SHALL abort the request with no array write and no response; reset asserted on the RESP-entry edge SHALL leave the write outcome undefined.
REQ-032 On deassertion, the first accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 With WAIT_CYCLES=0, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid one cycle after each accept, load rdata=0xDEADBEEF, err=0.
REQ-034 With word 0x10=0x80FF7F01, loads at 0x13 LB, 0x13 LBU, 0x12 LH, 0x12 LHU -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
REQ-035 On word 0x20=0, SB 0x21 data 0x000000AB, then SH 0x22 data 0x1234 -> LW 0x20 returns 0x1234AB00.
REQ-036 LW 0x11, LH 0x13, SW 0x4000 (DEPTH=4096) and funct3=3 load -> err=1, rdata=0; a subsequent LW of the targeted words shows unchanged contents.
REQ-037 With WAIT_CYCLES=3, req_valid held high continuously -> rsp_valid 4 cycles after accept, req_ready pattern 1,0,0,0,0,1.
REQ-038 With WAIT_CYCLES=3, SW issued and rst_n pulsed low in the 2nd WAIT cycle -> no rsp_valid, outputs at reset values, and a later LW of that word returns its old value.
